rr_arbiter8: RTL

- Round-robin arbiter sharing one resource between 8 requesters.
- Registered one-hot grant with lock-until-release semantics.
- Rotating priority pointer gives fair service.
- Combinational any-request detect is the OR of all `req` bits, implemented by an instance of the team's Or8Way gate. Grant decisions are made by a small state machine.

---
 rtl/rr_arbiter8.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant that is held until released.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces rotation after MAX_HOLD cycles.

module Or8Way (
    input  logic [7:0] bits,
    output logic       y
);

    // Reduction OR of all eight inputs.
    always_comb begin
        y = |bits;
    end

endmodule

module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       any_req
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if ((MAX_HOLD < 32'd1) || (MAX_HOLD > 32'd255)) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be within 1..255");
    end

    // Returns {found, index} of the first set bit of r, scanning start, start+1, ... modulo 8.
    function automatic logic [3:0] find_first(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            pos = start + 3'(k);
            if (r[pos]) begin
                res = {1'b1, pos};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] to_onehot(input logic [2:0] i);
        return 8'(8'd1 << i);
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_s;
    logic [7:0] grant_s;
    logic [2:0] idx_s;
    logic       valid_s;
    logic [7:0] others_s;
    logic [3:0] pick_ptr_s;
    logic [3:0] pick_next_s;
    logic [2:0] idx_inc_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);
    logic [7:0] hold_r;
    logic [7:0] hold_s;
`endif

    Or8Way u_any_req (
        .bits (req),
        .y    (any_req)
    );

    // Priority search candidates and next-state / next-grant decision.
    always_comb begin
        others_s    = req & ~grant;
        idx_inc_s   = grant_idx + 3'd1;
        pick_ptr_s  = find_first(req, ptr_r);
        pick_next_s = find_first(others_s, idx_inc_s);
        state_s     = state_r;
        ptr_s       = ptr_r;
        grant_s     = grant;
        idx_s       = grant_idx;
        valid_s     = grant_valid;
`ifdef ARB_TIMEOUT_EN
        hold_s      = hold_r;
`endif
        case (state_r)
            IDLE: begin
                if (any_req) begin
                    idx_s   = pick_ptr_s[2:0];
                    grant_s = to_onehot(pick_ptr_s[2:0]);
                    valid_s = 1'b1;
                    state_s = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_s  = 8'd0;
`endif
                end else begin
                    idx_s   = 3'd0;
                    grant_s = 8'h00;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                if (req[grant_idx]) begin
`ifdef ARB_TIMEOUT_EN
                    // Holder still requesting: rotate only once its budget is spent and someone waits.
                    if ((hold_r >= HOLD_LAST) && pick_next_s[3]) begin
                        idx_s   = pick_next_s[2:0];
                        grant_s = to_onehot(pick_next_s[2:0]);
                        ptr_s   = idx_inc_s;
                        hold_s  = 8'd0;
                    end else if (hold_r >= HOLD_LAST) begin
                        hold_s  = HOLD_LAST;
                    end else begin
                        hold_s  = hold_r + 8'd1;
                    end
`else
                    grant_s = grant;
`endif
                end else if (pick_next_s[3]) begin
                    idx_s   = pick_next_s[2:0];
                    grant_s = to_onehot(pick_next_s[2:0]);
                    ptr_s   = idx_inc_s;
`ifdef ARB_TIMEOUT_EN
                    hold_s  = 8'd0;
`endif
                end else begin
                    idx_s   = 3'd0;
                    grant_s = 8'h00;
                    valid_s = 1'b0;
                    ptr_s   = idx_inc_s;
                    state_s = IDLE;
                end
            end
            default: begin
                idx_s   = 3'd0;
                grant_s = 8'h00;
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_r      <= 8'd0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            grant       <= grant_s;
            grant_idx   <= idx_s;
            grant_valid <= valid_s;
`ifdef ARB_TIMEOUT_EN
            hold_r      <= hold_s;
`endif
        end
    end

endmodule
